// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the run/halt sequencer:
// state encoding, error-cause bit positions and the halt opcode.
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_HALT  = 2'd3
    } run_state_e;

    localparam int ERR_ZERO  = 0;
    localparam int ERR_NUM   = 1;
    localparam int ERR_ADDR  = 2;
    localparam int ERR_ALIGN = 3;

    localparam logic [31:0] HALT_INSTR_DEF = 32'hFFFF_FFFF;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             clear_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] r_count;

    // count up on inc, stop at the maximum value
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_count <= '0;
        end else if (clear_i) begin
            r_count <= '0;
        end else if (inc_i && (r_count != '1)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count_o = r_count;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/halt sequencer: gates architectural commit, handles
// pause / single-step, halts on fatal errors, logs error causes.
module cpu_run_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter logic [31:0] HALT_INSTR = HALT_INSTR_DEF,
    parameter int          CNT_W      = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             pause_i,
    input  logic             step_req_i,
    output logic             step_ack_o,
    input  logic [31:0]      instr_i,
    input  logic [31:0]      pc_i,
    input  logic             err_zero_i,
    input  logic             err_num_i,
    input  logic             addr_ovf_i,
    input  logic             misalign_i,
    output logic             commit_o,
    output logic [1:0]       state_o,
    output logic             halted_o,
    output logic [3:0]       err_cause_o,
    output logic [31:0]      err_pc_o,
    output logic [CNT_W-1:0] retired_o
);

    run_state_e  r_state;
    run_state_e  w_next;
    logic        r_ack;
    logic        w_ack_nxt;
    logic [3:0]  r_cause;
    logic [31:0] r_err_pc;
    logic        w_step;
    logic        w_exec;
    logic        w_fatal;
    logic        w_commit;
    logic [3:0]  w_cause;

    // exec window, fatal detection and the commit enable
    always_comb begin
        w_step   = (r_state == ST_PAUSE) && step_req_i && !r_ack;
        w_exec   = (r_state == ST_RUN) || w_step;
        w_fatal  = addr_ovf_i || misalign_i || (instr_i == HALT_INSTR);
        w_commit = w_exec && !w_fatal;
        w_cause            = '0;
        w_cause[ERR_ZERO]  = err_zero_i;
        w_cause[ERR_NUM]   = err_num_i;
        w_cause[ERR_ADDR]  = addr_ovf_i;
        w_cause[ERR_ALIGN] = misalign_i;
    end

    // next-state and step-acknowledge logic
    always_comb begin
        w_next    = r_state;
        // ack rises after a step cycle, then follows req until it drops
        w_ack_nxt = r_ack ? step_req_i : w_step;
        unique case (r_state)
            ST_IDLE: begin
                if (start_i) w_next = ST_RUN;
            end
            ST_RUN: begin
                if (w_fatal)      w_next = ST_HALT;
                else if (pause_i) w_next = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (w_step) begin
                    if (w_fatal) w_next = ST_HALT;
                end else if (!pause_i && !step_req_i && !r_ack) begin
                    w_next = ST_RUN;
                end
            end
            ST_HALT: begin
                w_next = ST_HALT;
            end
        endcase
    end

    // state and handshake registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ST_IDLE;
            r_ack   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ack   <= w_ack_nxt;
        end
    end

    // sticky error causes; PC of the first erroring instruction
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cause  <= '0;
            r_err_pc <= '0;
        end else if (w_exec) begin
            r_cause <= r_cause | w_cause;
            if ((r_cause == 4'd0) && (w_cause != 4'd0)) begin
                r_err_pc <= pc_i;
            end
        end
    end

    sat_counter #(
        .WIDTH   (CNT_W)
    ) u_retired (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (w_commit),
        .clear_i (1'b0),
        .count_o (retired_o)
    );

    assign commit_o    = w_commit;
    assign step_ack_o  = r_ack;
    assign state_o     = r_state;
    assign halted_o    = (r_state == ST_HALT);
    assign err_cause_o = r_cause;
    assign err_pc_o    = r_err_pc;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with an expectation queue
// drained against the DUT at each sample point.
module tb_cpu_run_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start, pause, step;
    logic [31:0] instr, pc;
    logic        ezero, enum_, eaddr, ealign;

    logic        ack, commit, halted;
    logic [1:0]  state;
    logic [3:0]  cause;
    logic [31:0] epc;
    logic [31:0] ret;

    logic        ack4, commit4, halted4;
    logic [1:0]  state4;
    logic [3:0]  cause4;
    logic [31:0] epc4;
    logic [3:0]  ret4;

    localparam int S_COMMIT = 0;
    localparam int S_STATE  = 1;
    localparam int S_ACK    = 2;
    localparam int S_HALTED = 3;
    localparam int S_CAUSE  = 4;
    localparam int S_EPC    = 5;
    localparam int S_RET    = 6;
    localparam int S_RET4   = 7;
    localparam int S_ST4    = 8;

    typedef struct {
        int          sel;
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    cpu_run_ctrl dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .pause_i(pause),
        .step_req_i(step), .step_ack_o(ack), .instr_i(instr),
        .pc_i(pc), .err_zero_i(ezero), .err_num_i(enum_),
        .addr_ovf_i(eaddr), .misalign_i(ealign), .commit_o(commit),
        .state_o(state), .halted_o(halted), .err_cause_o(cause),
        .err_pc_o(epc), .retired_o(ret)
    );

    cpu_run_ctrl #(.CNT_W(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .pause_i(pause),
        .step_req_i(step), .step_ack_o(ack4), .instr_i(instr),
        .pc_i(pc), .err_zero_i(ezero), .err_num_i(enum_),
        .addr_ovf_i(eaddr), .misalign_i(ealign), .commit_o(commit4),
        .state_o(state4), .halted_o(halted4), .err_cause_o(cause4),
        .err_pc_o(epc4), .retired_o(ret4)
    );

    function automatic logic [31:0] obs(int sel);
        case (sel)
            S_COMMIT: return 32'(commit);
            S_STATE:  return 32'(state);
            S_ACK:    return 32'(ack);
            S_HALTED: return 32'(halted);
            S_CAUSE:  return 32'(cause);
            S_EPC:    return epc;
            S_RET:    return ret;
            S_RET4:   return 32'(ret4);
            S_ST4:    return 32'(state4);
            default:  return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic push(int sel, string tag, logic [31:0] val);
        exp_t e;
        e.sel = sel;
        e.tag = tag;
        e.val = val;
        sbq.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] o;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            o = obs(e.sel);
            checks++;
            assert (o === e.val) else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h",
                       e.tag, o, e.val);
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic now_();
        #1;
        drain();
    endtask

    task automatic idle_inputs();
        start = 0; pause = 0; step = 0;
        instr = 32'h0; pc = 32'h0;
        ezero = 0; enum_ = 0; eaddr = 0; ealign = 0;
    endtask

    task automatic push_reset(string tag);
        push(S_STATE,  tag, 0);
        push(S_COMMIT, tag, 0);
        push(S_ACK,    tag, 0);
        push(S_HALTED, tag, 0);
        push(S_CAUSE,  tag, 0);
        push(S_EPC,    tag, 0);
        push(S_RET,    tag, 0);
        push(S_RET4,   tag, 0);
    endtask

    task automatic reset_chk(string tag);
        idle_inputs();
        rst = 0;
        push_reset(tag);
        now_();
        @(posedge clk);
        #1;
        rst = 1;
    endtask

    initial begin
        idle_inputs();
        #3;
        reset_chk("rst0");

        // start, five ordinary instructions, then halt opcode
        start = 1;
        push(S_COMMIT, "idle_commit", 0);
        now_();
        push(S_STATE, "start_run", 1);
        cyc();
        start = 0;
        for (int k = 0; k < 5; k++) begin
            pc = 32'(k * 4);
            push(S_COMMIT, "run_commit", 1);
            now_();
            cyc();
        end
        push(S_RET, "ret5", 5);
        instr = 32'hFFFF_FFFF;
        push(S_COMMIT, "halt_commit", 0);
        now_();
        push(S_STATE, "halt_state", 3);
        push(S_HALTED, "halted", 1);
        push(S_RET, "halt_ret", 5);
        cyc();
        instr = 32'h0;
        start = 1;
        push(S_STATE, "halt_start", 3);
        push(S_COMMIT, "halt_nocommit", 0);
        cyc();
        start = 0;

        // misalign in RUN
        reset_chk("rst1");
        start = 1;
        cyc();
        start = 0;
        pc = 32'h40;
        ealign = 1;
        push(S_COMMIT, "mis_commit", 0);
        now_();
        push(S_STATE, "mis_state", 3);
        push(S_CAUSE, "mis_cause", 4'b1000);
        push(S_EPC, "mis_pc", 32'h40);
        cyc();
        ealign = 0;

        // non-fatal errors still commit
        reset_chk("rst2");
        start = 1;
        cyc();
        start = 0;
        pc = 32'h10;
        ezero = 1;
        push(S_COMMIT, "zero_commit", 1);
        now_();
        cyc();
        ezero = 0;
        enum_ = 1;
        pc = 32'h14;
        push(S_COMMIT, "num_commit", 1);
        now_();
        push(S_CAUSE, "nf_cause", 4'b0011);
        push(S_EPC, "nf_pc", 32'h10);
        push(S_STATE, "nf_state", 1);
        cyc();
        enum_ = 0;

        // pause and single-step
        pause = 1;
        push(S_COMMIT, "pause_last", 1);
        now_();
        push(S_STATE, "pause_state", 2);
        cyc();
        push(S_COMMIT, "paused_commit", 0);
        now_();
        for (int s = 0; s < 3; s++) begin
            step = 1;
            push(S_COMMIT, "step_commit", 1);
            now_();
            push(S_ACK, "step_ack", 1);
            push(S_COMMIT, "step_once", 0);
            cyc();
            push(S_COMMIT, "step_hold", 0);
            cyc();
            step = 0;
            push(S_ACK, "step_ackclr", 0);
            push(S_STATE, "step_state", 2);
            cyc();
        end
        push(S_RET, "step_ret", 6);
        now_();
        step = 1;
        cyc();
        cyc();
        cyc();
        push(S_RET, "hold4_ret", 7);
        cyc();
        step = 0;
        push(S_ACK, "hold4_ackclr", 0);
        cyc();
        pause = 0;
        push(S_STATE, "resume_run", 1);
        cyc();
        push(S_COMMIT, "resume_commit", 1);
        now_();

        // fatal during a step
        reset_chk("rst3");
        start = 1;
        cyc();
        start = 0;
        pause = 1;
        cyc();
        step = 1;
        eaddr = 1;
        push(S_COMMIT, "sf_commit", 0);
        now_();
        push(S_ACK, "sf_ack", 1);
        push(S_STATE, "sf_state", 3);
        push(S_HALTED, "sf_halted", 1);
        push(S_CAUSE, "sf_cause", 4'b0100);
        push(S_RET, "sf_ret", 1);
        cyc();
        step = 0;
        eaddr = 0;
        push(S_ACK, "sf_ackclr", 0);
        push(S_STATE, "sf_stay", 3);
        cyc();

        // saturation of a 4-bit counter, async reset mid-RUN
        reset_chk("rst4");
        pause = 0;
        start = 1;
        cyc();
        start = 0;
        for (int i = 0; i < 14; i++) cyc();
        push(S_RET4, "ret4_14", 14);
        now_();
        for (int i = 0; i < 6; i++) cyc();
        push(S_RET4, "ret4_sat", 15);
        push(S_RET, "ret_20", 20);
        push(S_ST4, "st4_run", 1);
        now_();
        rst = 0;
        push_reset("async_rst");
        now_();
        @(posedge clk);
        #1;
        rst = 1;
        push(S_STATE, "post_rst", 0);
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run/halt sequencer for the single-cycle MIPS core. It gates every architectural commit (PC update, register write, data-memory write) through one enable. It starts the core on command, supports pause and handshaked single-step, and halts on fatal data-memory errors or on the halt opcode. It also records sticky error causes with the faulting PC and counts retired instructions.

## Interface
- HALT_INSTR, 32'hFFFFFFFF, instruction word that halts the core
- CNT_W, 32, width of retired-instruction counter
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- start_i  in  1  start pulse; only honoured in IDLE
- pause_i  in  1  level; request pause at next instruction boundary
- step_req_i  in  1  single-step request, 4-phase handshake
- step_ack_o  out  1  single-step acknowledge
- instr_i  in  32  instruction at current PC
- pc_i  in  32  current PC
- err_zero_i, err_num_i, addr_ovf_i, misalign_i  in  1 each  datapath error flags for current instruction
- commit_o  out  1  combinational; enables PC load, RegWrite and MemWrite this cycle
- state_o  out  2  IDLE=0, RUN=1, PAUSE=2, HALT=3
- halted_o  out  1  state==HALT
- err_cause_o  out  4  sticky: [0] zero-reg write, [1] arithmetic overflow, [2] address overflow, [3] misalign
- err_pc_o  out  32  pc_i of the first instruction that raised any error
- retired_o  out  CNT_W  committed-instruction count

## Operation
- exec window = (state==RUN) or (state==PAUSE and step_req_i and not step_ack_o).
- fatal = addr_ovf_i | misalign_i | (instr_i==HALT_INSTR).
- commit_o = exec window & ~fatal.
- err_zero_i and err_num_i are non-fatal: recorded, and the instruction still commits.
- IDLE: commit_o=0. start_i goes to RUN.
- RUN: fatal goes to HALT, and that instruction does not commit. Otherwise, pause_i goes to PAUSE after the current instruction commits. Otherwise stay in RUN.
- PAUSE: commit_o=0 except in a step cycle.
  - Step cycle: at most one instruction executes. step_ack_o rises the next edge and holds until step_req_i is sampled low, then clears.
  - Fatal in a step cycle: go to HALT and still raise step_ack_o.
  - pause_i low and no step outstanding (step_req_i low, step_ack_o low): go to RUN.
  - A step request stays pending until acknowledged, even if pause_i drops.
- HALT: terminal until reset. start_i, pause_i and step_req_i are ignored, except that step_ack_o completes its 4-phase handshake.
- Error capture happens only in the exec window, whether or not the instruction commits.
  - err_cause_o |= {misalign, addr_ovf, num, zero}.
  - err_pc_o loads pc_i only when err_cause_o was all-zero before the edge.
  - Simultaneous errors set all corresponding bits in the same edge.
- retired_o increments on each commit_o=1 edge and saturates at all-ones (no wrap).

## Timing
- Reset values: state IDLE, commit_o 0, step_ack_o 0, halted_o 0, err_cause_o 0, err_pc_o 0, retired_o 0.
- Reset mid-step aborts the handshake. step_ack_o is 0 immediately, asynchronously.
- commit_o is combinational from state, step handshake, instr_i and the error inputs, with zero latency. Every other output is registered.
- Transitions take effect on the edge following the triggering condition. First commit is the cycle after start_i is sampled.
- Step latency: request sampled at edge N, instruction executes in cycle N to N+1, ack visible after edge N+1.
- pause_i and fatal in the same RUN cycle: fatal wins, go to HALT.
- start_i in any state other than IDLE is a no-op.

## Structure
- Shared package cpu_ctrl_pkg holds:
  - state encoding (IDLE/RUN/PAUSE/HALT)
  - err_cause bit indices
  - default HALT_INSTR
- Sub-module sat_counter (parameter width; inputs inc, clear; output count) provides retired_o.
- The FSM, step handshake and error capture stay in the top module.

## Test plan
- Reset, start_i pulse, 5 ordinary instructions: commit_o=1 for 5 cycles and retired_o=5. Next instr_i=32'hFFFFFFFF: commit_o=0 that cycle, state_o=3, retired_o stays 5.
- RUN with misalign_i=1 at pc_i=0x40: commit_o=0 that cycle, state_o=3, err_cause_o=4'b1000, err_pc_o=0x40.
- err_zero_i at pc 0x10, then err_num_i at pc 0x14: both commit, err_cause_o=4'b0011, err_pc_o=0x10, state stays RUN.
- pause_i high: state_o=2, commit_o=0. Three 4-phase steps give retired_o +3 and exactly one commit each. Holding step_req_i high 4 cycles commits only once. Drop pause_i: back to RUN.
- Step with addr_ovf_i=1: no commit, step_ack_o=1 next cycle, state_o=3, err_cause_o=4'b0100.
- CNT_W=4 with 20 commits: retired_o saturates at 15. rst_i low mid-RUN: all outputs return to reset values asynchronously.
